mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the pipeline's instruction-fetch requester (read-only) and its MEM-stage data requester (read/write).
- Sequences one transaction at a time through an issue/response handshake.
- Gives data accesses priority, with a starvation bound that protects fetch.
- Sits between the pipeline top level and the memory, replacing separate inst_mem/data_mem ports.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter_arb_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the unified-memory port arbiter: FSM state encoding,
// transaction owner encoding and default bus widths.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_MAX_D_STREAK = 4;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } arb_owner_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and single memory port signals.
//   master : the arbiter's view (takes requests, drives the memory port)
//   slave  : the environment's view (requesters and memory)
// Fetch  : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
// Data   : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
// Memory : mem_req/mem_we/mem_addr/mem_wdata out, mem_ready/mem_rvalid/mem_rdata in
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_arb_pick
// Combinational arbitration: data wins unless fetch is waiting and data has
// already taken MAX_D_STREAK grants in a row.
//   if_req_i, d_req_i : pending requests
//   d_streak_i        : consecutive data grants taken while fetch waited
//   pick_valid_o      : some requester is pending
//   pick_owner_o      : winner
//   next_streak_o     : streak value to store if this pick is taken
// -----------------------------------------------------------------------------
module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int SW           = $clog2(MAX_D_STREAK + 1)
) (
    input  logic          if_req_i,
    input  logic          d_req_i,
    input  logic [SW-1:0] d_streak_i,
    output logic          pick_valid_o,
    output arb_owner_e    pick_owner_o,
    output logic [SW-1:0] next_streak_o
);

    localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

    logic pick_d;

    assign pick_d       = d_req_i && (!if_req_i || (d_streak_i < MAX_S));
    assign pick_valid_o = if_req_i || d_req_i;
    assign pick_owner_o = pick_d ? OWNER_D : OWNER_IF;

    // The streak only grows while fetch is actually being held off; any
    // fetch win or uncontested data win clears it.
    always_comb begin
        next_streak_o = '0;
        if (pick_d && if_req_i) begin
            next_streak_o = (d_streak_i >= MAX_S) ? MAX_S : d_streak_i + 1'b1;
        end
    end

endmodule : mem_port_arbiter_arb_pick

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (read-only) and the
// MEM-stage data requester, one transaction at a time (IDLE -> ISSUE -> WAIT).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : requester and memory signals (mem_port_arbiter_if.master)
//   busy_o   : FSM is not IDLE
//   err_o    : sticky, a memory response arrived outside WAIT
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus,
    output logic                busy_o,
    output logic                err_o
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_e            state_q,  state_d;
    arb_owner_e            owner_q,  owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  we_q,     we_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  err_q,    err_d;

    logic                  pick_valid;
    arb_owner_e            pick_owner;
    logic [SW-1:0]         next_streak;

    logic                  take_pick;
    logic                  mem_req;
    logic                  if_gnt, d_gnt, if_rvalid, d_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata, d_rdata;

    mem_port_arbiter_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .SW           (SW)
    ) u_arb_pick (
        .if_req_i      (bus.if_req),
        .d_req_i       (bus.d_req),
        .d_streak_i    (streak_q),
        .pick_valid_o  (pick_valid),
        .pick_owner_o  (pick_owner),
        .next_streak_o (next_streak)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        streak_d  = streak_q;
        err_d     = err_q || (bus.mem_rvalid && (state_q != ST_WAIT));
        take_pick = 1'b0;
        mem_req   = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;

        case (state_q)
            ST_IDLE: begin
                take_pick = pick_valid;
            end
            ST_ISSUE: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    if_gnt  = (owner_q == OWNER_IF);
                    d_gnt   = (owner_q == OWNER_D);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (owner_q == OWNER_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = bus.mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = bus.mem_rdata;
                    end
                    // Re-arbitrate in the response cycle for back-to-back issue.
                    take_pick = pick_valid;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Latch the winner's transaction; it is committed from here on.
        if (take_pick) begin
            state_d  = ST_ISSUE;
            owner_d  = pick_owner;
            streak_d = next_streak;
            if (pick_owner == OWNER_D) begin
                addr_d  = bus.d_addr;
                we_d    = bus.d_we;
                wdata_d = bus.d_wdata;
            end else begin
                addr_d  = bus.if_addr;
                we_d    = 1'b0;
                wdata_d = '0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_IF;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = we_q && (state_q == ST_ISSUE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_rdata   = d_rdata;

    assign busy_o = (state_q != ST_IDLE);
    assign err_o  = err_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The bench plays both requesters and
// the memory; inputs change 1 time unit after a rising edge and outputs are
// sampled 1 time unit later, well away from either clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;
    logic busy_o;
    logic err_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MAX_D_STREAK (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.master),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:10] pat;

        rst            = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // Reset state
        #2;
        check("rst_busy",    32'(busy_o),       32'd0);
        check("rst_mem_req", 32'(bus.mem_req),  32'd0);
        check("rst_addr",    bus.mem_addr,      32'd0);
        check("rst_err",     32'(err_o),        32'd0);
        cyc();
        rst = 1'b1;

        // Single fetch, ready immediately, 1-cycle memory
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h04; bus.mem_ready = 1'b1;
        #1;
        check("f1_c0_busy", 32'(busy_o), 32'd0);
        cyc();
        #1;
        check("f1_c1_mem_req", 32'(bus.mem_req), 32'd1);
        check("f1_c1_addr",    bus.mem_addr,      32'h04);
        check("f1_c1_if_gnt",  32'(bus.if_gnt),   32'd1);
        check("f1_c1_we",      32'(bus.mem_we),   32'd0);
        cyc();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00A00093;
        #1;
        check("f1_c2_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("f1_c2_if_rdata",  bus.if_rdata,       32'h00A00093);
        check("f1_c2_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        check("f1_c2_mem_req",   32'(bus.mem_req),   32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("f1_c3_busy",     32'(busy_o),       32'd0);
        check("f1_c3_if_rdata", bus.if_rdata,      32'd0);

        // Simultaneous fetch and load: data first, fetch back-to-back
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h08;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        cyc();
        #1;
        check("sim_d_addr",  bus.mem_addr,     32'h200);
        check("sim_d_gnt",   32'(bus.d_gnt),   32'd1);
        check("sim_if_gnt0", 32'(bus.if_gnt),  32'd0);
        cyc();
        bus.d_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11112222;
        #1;
        check("sim_d_rvalid",  32'(bus.d_rvalid),  32'd1);
        check("sim_d_rdata",   bus.d_rdata,        32'h11112222);
        check("sim_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("sim_f_mem_req", 32'(bus.mem_req), 32'd1);
        check("sim_f_addr",    bus.mem_addr,     32'h08);
        check("sim_f_gnt",     32'(bus.if_gnt),  32'd1);
        cyc();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h33334444;
        #1;
        check("sim_f_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("sim_f_rdata",  bus.if_rdata,       32'h33334444);
        check("sim_f_d_rdata_zero", bus.d_rdata,  32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("sim_idle", 32'(busy_o), 32'd0);

        // Starvation bound: both held, expect D D D D F D D D D F D
        pat = 11'b11110111101;
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_addr = 32'h400;
        for (int i = 0; i < 11; i++) begin
            cyc();
            bus.mem_rvalid = 1'b0;
            if (i == 10) begin
                bus.if_req = 1'b0; bus.d_req = 1'b0;
            end
            #1;
            check($sformatf("stk_d_gnt_%0d", i),  32'(bus.d_gnt),  32'(pat[i]));
            check($sformatf("stk_if_gnt_%0d", i), 32'(bus.if_gnt), 32'(!pat[i]));
            check($sformatf("stk_addr_%0d", i),   bus.mem_addr, pat[i] ? 32'h400 : 32'h10);
            cyc();
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'(i);
            #1;
            check($sformatf("stk_d_rv_%0d", i),  32'(bus.d_rvalid),  32'(pat[i]));
            check($sformatf("stk_if_rv_%0d", i), 32'(bus.if_rvalid), 32'(!pat[i]));
        end
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("stk_idle", 32'(busy_o), 32'd0);

        // Store with memory stalled for 3 cycles; requester drops req early
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
        bus.d_wdata = 32'hDEADBEEF; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 1) bus.d_req = 1'b0;
            #1;
            check($sformatf("st_req_%0d", i),   32'(bus.mem_req), 32'd1);
            check($sformatf("st_we_%0d", i),    32'(bus.mem_we),  32'd1);
            check($sformatf("st_addr_%0d", i),  bus.mem_addr,     32'h300);
            check($sformatf("st_wdata_%0d", i), bus.mem_wdata,    32'hDEADBEEF);
            check($sformatf("st_gnt_%0d", i),   32'(bus.d_gnt),   32'd0);
        end
        cyc();
        bus.mem_ready = 1'b1;
        #1;
        check("st_gnt",    32'(bus.d_gnt),  32'd1);
        check("st_we_gnt", 32'(bus.mem_we), 32'd1);
        cyc();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
        #1;
        check("st_rvalid", 32'(bus.d_rvalid), 32'd1);
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("st_idle", 32'(busy_o), 32'd0);
        check("st_err",  32'(err_o),  32'd0);

        // Stray response in IDLE sets sticky err_o and is not forwarded
        cyc();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555AAAA;
        #1;
        check("err_no_if_rv", 32'(bus.if_rvalid), 32'd0);
        check("err_no_d_rv",  32'(bus.d_rvalid),  32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("err_set", 32'(err_o), 32'd1);
        cyc();
        cyc();
        #1;
        check("err_sticky", 32'(err_o), 32'd1);

        // Reset mid-WAIT with data owner, then a clean fetch
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.mem_ready = 1'b1;
        cyc();
        #1;
        check("rw_d_gnt", 32'(bus.d_gnt), 32'd1);
        cyc();
        bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        #1;
        check("rw_busy_wait", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        check("rw_busy",    32'(busy_o),       32'd0);
        check("rw_mem_req", 32'(bus.mem_req),  32'd0);
        check("rw_addr",    bus.mem_addr,      32'd0);
        check("rw_d_rv",    32'(bus.d_rvalid), 32'd0);
        check("rw_err",     32'(err_o),        32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_ready = 1'b1;
        #1;
        check("rw_c0_d_rv", 32'(bus.d_rvalid), 32'd0);
        cyc();
        #1;
        check("rw_f_addr", bus.mem_addr,     32'h100);
        check("rw_f_req",  32'(bus.mem_req), 32'd1);
        check("rw_f_gnt",  32'(bus.if_gnt),  32'd1);
        cyc();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        #1;
        check("rw_f_rv",   32'(bus.if_rvalid), 32'd1);
        check("rw_f_data", bus.if_rdata,       32'hCAFEF00D);
        check("rw_no_d",   32'(bus.d_rvalid),  32'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        #1;
        check("rw_idle", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_mem_port_arbiter
